// File: rtl/psram_arb_pkg.sv
// Shared types and constants for the PSRAM Wishbone arbiter.
// Configuration macro (see psram_arb_picker): PSRAM_ARB_FIXED_PRIO_EN.
package psram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Idle cycles forced on the controller side between two grants.
    localparam int GAP_CYC = 1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/psram_arb_picker.sv
// Combinational winner selection among the requesting masters.
// PSRAM_ARB_FIXED_PRIO_EN defined: lowest index wins; undefined: round-robin after last_i.
module psram_arb_picker
    import psram_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int IW      = idx_w(NUM_MST)
) (
    input  logic [NUM_MST-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               valid_o,
    output logic [IW-1:0]      win_o
);

`ifdef PSRAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = ^last_i;

    always_comb begin
        valid_o = |req_i;
        win_o   = '0;
        for (int k = NUM_MST - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                win_o = IW'(k);
            end
        end
    end
`else
    int   idx;
    logic found;

    // Search starts one past the previous winner so every requester is served in turn.
    always_comb begin
        valid_o = |req_i;
        win_o   = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_MST; k++) begin
            idx = (int'(last_i) + 1 + k) % NUM_MST;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win_o = IW'(idx);
            end
        end
    end
`endif

endmodule

// File: rtl/psram_wb_arbiter.sv
// Shares one non-abortable PSRAM Wishbone controller between NUM_MST masters.
// Latches the winning request, holds it until ack, then idles the bus one cycle (PSRAM_ARB_FIXED_PRIO_EN selects fixed priority).
module psram_wb_arbiter
    import psram_arb_pkg::*;
#(
    parameter int NUM_MST = 2,
    parameter int AW      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_MST*AW-1:0] m_adr_i,
    input  logic [NUM_MST*32-1:0] m_dat_i,
    input  logic [NUM_MST*4-1:0]  m_sel_i,
    input  logic [NUM_MST-1:0]    m_we_i,
    input  logic [NUM_MST-1:0]    m_cyc_i,
    input  logic [NUM_MST-1:0]    m_stb_i,
    output logic [NUM_MST-1:0]    m_ack_o,
    output logic [31:0]           m_dat_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [31:0]           s_dat_o,
    output logic [3:0]            s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            dbg_state_o
);

    localparam int IW = idx_w(NUM_MST);

    arb_state_e          state_q;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       last_q;
    logic [3:0]          gap_cnt_q;
    logic [AW-1:0]       adr_q;
    logic [31:0]         dat_q;
    logic [3:0]          sel_q;
    logic                we_q;
    logic                cyc_q;

    logic [NUM_MST-1:0]  req;
    logic                pick_valid;
    logic [IW-1:0]       pick_win;

    assign req = m_cyc_i & m_stb_i;

    psram_arb_picker #(
        .NUM_MST (NUM_MST),
        .IW      (IW)
    ) u_picker (
        .req_i   (req),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .win_o   (pick_win)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= IW'(NUM_MST - 1);
            gap_cnt_q <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_win;
                        last_q  <= pick_win;
                        adr_q   <= m_adr_i[int'(pick_win)*AW +: AW];
                        dat_q   <= m_dat_i[int'(pick_win)*32 +: 32];
                        sel_q   <= m_sel_i[int'(pick_win)*4 +: 4];
                        we_q    <= m_we_i[pick_win];
                        cyc_q   <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Master inputs are ignored here; only the controller ack ends the transfer.
                    if (s_ack_i) begin
                        cyc_q     <= 1'b0;
                        gap_cnt_q <= '0;
                        state_q   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'(GAP_CYC - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ack is swallowed if the granted master has already dropped its cycle.
    always_comb begin
        m_ack_o = '0;
        if ((state_q == BUSY) && s_ack_i && m_cyc_i[grant_q]) begin
            m_ack_o[grant_q] = 1'b1;
        end
    end

    assign m_dat_o     = s_dat_i;
    assign s_adr_o     = adr_q;
    assign s_dat_o     = dat_q;
    assign s_sel_o     = sel_q;
    assign s_we_o      = we_q;
    assign s_cyc_o     = cyc_q;
    assign s_stb_o     = cyc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Self-checking bench for psram_wb_arbiter: transaction-level reference model, per-cycle compare,
// and directed scenarios with literal expectations (honours PSRAM_ARB_FIXED_PRIO_EN).
module tb_psram_wb_arbiter;

    localparam int NM = 2;
    localparam int AW = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NM*AW-1:0] m_adr;
    logic [NM*32-1:0] m_wdat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we;
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_ack;
    logic [31:0]      m_rdat;
    logic [AW-1:0]    s_adr;
    logic [31:0]      s_wdat;
    logic [3:0]       s_sel;
    logic             s_we;
    logic             s_cyc;
    logic             s_stb;
    logic [31:0]      s_rdat;
    logic             s_ack;
    logic [1:0]       dbg_state;

    always #5 clk = ~clk;

    psram_wb_arbiter #(.NUM_MST(NM), .AW(AW)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .m_adr_i     (m_adr),
        .m_dat_i     (m_wdat),
        .m_sel_i     (m_sel),
        .m_we_i      (m_we),
        .m_cyc_i     (m_cyc),
        .m_stb_i     (m_stb),
        .m_ack_o     (m_ack),
        .m_dat_o     (m_rdat),
        .s_adr_o     (s_adr),
        .s_dat_o     (s_wdat),
        .s_sel_o     (s_sel),
        .s_we_o      (s_we),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_dat_i     (s_rdat),
        .s_ack_i     (s_ack),
        .dbg_state_o (dbg_state)
    );

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, then a single quiet cycle.
    bit          mdl_busy  = 1'b0;
    bit          mdl_gap   = 1'b0;
    int          mdl_owner = 0;
    int          mdl_ptr   = 0;
    logic [31:0] mdl_adr   = '0;
    logic [31:0] mdl_dat   = '0;
    logic [3:0]  mdl_sel   = '0;
    logic        mdl_we    = 1'b0;
    int          grant_log[$];

    always @(posedge clk) begin : model
        int w;
        int idx;
        w = -1;
        if (!rst_n) begin
            mdl_busy <= 1'b0;
            mdl_gap  <= 1'b0;
            mdl_ptr  <= 0;
        end else if (mdl_busy) begin
            if (s_ack) begin
                mdl_busy <= 1'b0;
                mdl_gap  <= 1'b1;
            end
        end else if (mdl_gap) begin
            mdl_gap <= 1'b0;
        end else begin
            for (int k = 0; k < NM; k++) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (mdl_ptr + k) % NM;
`endif
                if (w < 0 && m_cyc[idx] && m_stb[idx]) w = idx;
            end
            if (w >= 0) begin
                mdl_busy  <= 1'b1;
                mdl_owner <= w;
                mdl_ptr   <= (w + 1) % NM;
                mdl_adr   <= m_adr[w*AW +: AW];
                mdl_dat   <= m_wdat[w*32 +: 32];
                mdl_sel   <= m_sel[w*4 +: 4];
                mdl_we    <= m_we[w];
                grant_log.push_back(w);
            end
        end
    end

    // Captured at every acked cycle for the directed checks.
    logic [NM-1:0] ack_who[$];
    logic [31:0]   ack_rdat[$];
    logic [31:0]   ack_sadr[$];
    logic [31:0]   ack_sdat[$];
    logic [3:0]    ack_ssel[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                logic [NM-1:0] exp_ack;
                exp_ack = '0;
                if (mdl_busy && s_ack && m_cyc[mdl_owner]) exp_ack[mdl_owner] = 1'b1;
                check("s_cyc", s_cyc, mdl_busy);
                check("s_stb", s_stb, mdl_busy);
                check("m_ack", m_ack, exp_ack);
                check("m_ack_onehot", $countones(m_ack) <= 1, 1);
                check("m_dat", m_rdat, s_rdat);
                if (mdl_busy) begin
                    check("s_adr", s_adr, mdl_adr);
                    check("s_dat", s_wdat, mdl_dat);
                    check("s_sel", s_sel, mdl_sel);
                    check("s_we", s_we, mdl_we);
                end
                if (m_ack != '0) begin
                    ack_who.push_back(m_ack);
                    ack_rdat.push_back(m_rdat);
                    ack_sadr.push_back(s_adr);
                    ack_sdat.push_back(s_wdat);
                    ack_ssel.push_back(s_sel);
                end
            end
        end
    end

    // Controller stand-in: acks slv_lat cycles after seeing the strobe.
    int          slv_lat  = 1;
    logic [31:0] slv_data = 32'h0;
    bit          poke_ack = 1'b0;
    int          wait_cnt = 0;

    initial begin
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (s_stb && !s_ack) begin
                if (wait_cnt >= slv_lat) begin
                    s_ack    = 1'b1;
                    s_rdat   = slv_data;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                s_ack    = poke_ack;
                wait_cnt = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_m(input int k, input bit req, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input bit we);
        m_cyc[k]           = req;
        m_stb[k]           = req;
        m_adr[k*AW +: AW]  = adr;
        m_wdat[k*32 +: 32] = dat;
        m_sel[k*4 +: 4]    = sel;
        m_we[k]            = we;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        ack_who.delete();
        ack_rdat.delete();
        ack_sadr.delete();
        ack_sdat.delete();
        ack_ssel.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_ack(input int k, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (m_ack[k]) ok = 1'b1;
        end
        check(name, ok, 1'b1);
        tick(1);
    endtask

    task automatic wait_stb(input bit level, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick(1);
            if (s_stb == level) ok = 1'b1;
        end
        check(name, ok, 1'b1);
    endtask

    initial begin : stimulus
        int n_before;
        m_adr = '0; m_wdat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        tick(1);
        do_reset();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_s_cyc", s_cyc, 1'b0);
        check("rst_s_stb", s_stb, 1'b0);
        check("rst_s_we", s_we, 1'b0);
        check("rst_m_ack", m_ack, 2'b00);
        check("rst_state", dbg_state, 2'd0);
        tick(1);

        // Single master read
        clear_logs();
        slv_lat  = 1;
        slv_data = 32'hDEAD_BEEF;
        drive_m(0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
        @(negedge clk);
        check("t1_stb_before", s_stb, 1'b0);
        tick(1);
        check("t1_stb_rise", s_stb, 1'b1);
        check("t1_adr", s_adr, 32'h0000_0100);
        check("t1_we", s_we, 1'b0);
        wait_ack(0, "t1_ack_seen");
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("t1_gap_stb", s_stb, 1'b0);
        check("t1_ack_cnt", ack_who.size(), 1);
        if (ack_who.size() > 0) begin
            check("t1_ack_who", ack_who[0], 2'b01);
            check("t1_ack_rdat", ack_rdat[0], 32'hDEAD_BEEF);
        end
        tick(3);

        // Contention, both masters continuously requesting
        do_reset();
        clear_logs();
        slv_lat  = 0;
        slv_data = 32'h0BAD_F00D;
        drive_m(0, 1'b1, 32'h0000_1000, 32'h0, 4'hF, 1'b0);
        drive_m(1, 1'b1, 32'h0000_1001, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 80 && ack_who.size() < 4; i++) @(negedge clk);
        check("t2_ack_cnt", ack_who.size() >= 4, 1'b1);
        tick(1);
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        if (ack_who.size() >= 4 && grant_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef PSRAM_ARB_FIXED_PRIO_EN
                check($sformatf("t2_ack_who%0d", i), ack_who[i], 2'b01);
                check($sformatf("t2_grant%0d", i), grant_log[i], 0);
`else
                check($sformatf("t2_ack_who%0d", i), ack_who[i], (i % 2 == 0) ? 2'b01 : 2'b10);
                check($sformatf("t2_grant%0d", i), grant_log[i], i % 2);
`endif
            end
        end
        tick(4);

        // Stability of the latched write while the master changes its inputs
        clear_logs();
        slv_lat  = 3;
        slv_data = 32'h0;
        drive_m(0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011, 1'b1);
        wait_stb(1'b1, "t3_stb_rise");
        drive_m(0, 1'b1, 32'hFFFF_0000, 32'hCAFE_F00D, 4'b1100, 1'b0);
        wait_ack(0, "t3_ack_seen");
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("t3_ack_cnt", ack_who.size(), 1);
        if (ack_who.size() > 0) begin
            check("t3_sadr", ack_sadr[0], 32'h0000_0200);
            check("t3_sdat", ack_sdat[0], 32'h1234_5678);
            check("t3_ssel", ack_ssel[0], 4'b0011);
        end
        tick(3);

        // Abort: m1 drops cyc two cycles into BUSY
        clear_logs();
        slv_lat = 4;
        drive_m(1, 1'b1, 32'h0000_0300, 32'h0, 4'hF, 1'b0);
        wait_stb(1'b1, "t4_stb_rise");
        tick(2);
        drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        check("t4_stb_held", s_stb, 1'b1);
        wait_stb(1'b0, "t4_stb_fall");
        check("t4_no_ack", ack_who.size(), 0);
        check("t4_grant_cnt", grant_log.size(), 1);
        if (grant_log.size() > 0) check("t4_grant", grant_log[0], 1);
        tick(2);
        check("t4_idle_state", dbg_state, 2'd0);

        // Ack from the controller while idle is ignored
        poke_ack = 1'b1;
        tick(1);
        @(negedge clk);
        check("t5_idle_m_ack", m_ack, 2'b00);
        check("t5_idle_cyc", s_cyc, 1'b0);
        check("t5_idle_state", dbg_state, 2'd0);
        tick(1);
        poke_ack = 1'b0;
        tick(3);

        // Reset in the middle of a transfer
        do_reset();
        clear_logs();
        slv_lat  = 10;
        slv_data = 32'h5555_AAAA;
        drive_m(0, 1'b1, 32'h0000_0400, 32'h0, 4'hF, 1'b0);
        drive_m(1, 1'b1, 32'h0000_0500, 32'h0, 4'hF, 1'b0);
        wait_stb(1'b1, "t6_stb_rise");
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n   = 1'b1;
        slv_lat = 1;
        check("t6_rst_cyc", s_cyc, 1'b0);
        check("t6_rst_m_ack", m_ack, 2'b00);
        check("t6_rst_state", dbg_state, 2'd0);
        check("t6_pre_acks", ack_who.size(), 0);
        ack_who.delete();
        wait_ack(0, "t6_ack_seen");
        drive_m(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        drive_m(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        check("t6_ack_cnt", ack_who.size() >= 1, 1'b1);
        if (ack_who.size() > 0) check("t6_first_who", ack_who[0], 2'b01);
        check("t6_grant_cnt", grant_log.size(), 2);
        if (grant_log.size() >= 2) begin
            check("t6_grant0", grant_log[0], 0);
            check("t6_grant1", grant_log[1], 0);
        end
        tick(6);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
